// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   md_op_e  : operation codes carried on md_op
//   state_e  : sequencer states
//   HILO_SEL_* : mthi/mtlo target select
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational multiply/divide datapath.
// Ports:
//   md_op       in  2   operation (mult/multu/div/divu)
//   src_a       in  32  rs operand (multiplicand / dividend)
//   src_b       in  32  rt operand (multiplier / divisor)
//   res_hi      out 32  HI result (product[63:32] or remainder)
//   res_lo      out 32  LO result (product[31:0] or quotient)
//   div_by_zero out 1   divide with src_b == 0; results are then meaningless
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    md_op_e      op_s;
    logic [63:0] prod_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        neg_a_s;
    logic        neg_b_s;

    assign op_s = md_op_e'(md_op);

    // Select the operation and form the 64-bit result pair.
    always_comb begin
        prod_s      = 64'd0;
        mag_a_s     = src_a;
        mag_b_s     = src_b;
        quo_s       = 32'd0;
        rem_s       = 32'd0;
        neg_a_s     = 1'b0;
        neg_b_s     = 1'b0;
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (op_s)
            MD_MULT: begin
                // Low 64 bits of a 64x64 product of sign-extended operands
                // equal the signed 32x32 product.
                prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                prod_s = {32'd0, src_a} * {32'd0, src_b};
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                div_by_zero = (src_b == 32'd0);
                if (op_s == MD_DIV) begin
                    // Divide magnitudes, then fix signs: quotient truncates
                    // toward zero, remainder follows the dividend.
                    // 0x80000000 / -1 wraps naturally to 0x80000000, rem 0.
                    neg_a_s = src_a[31];
                    neg_b_s = src_b[31];
                    mag_a_s = neg_a_s ? (32'd0 - src_a) : src_a;
                    mag_b_s = neg_b_s ? (32'd0 - src_b) : src_b;
                end else begin
                    neg_a_s = 1'b0;
                    neg_b_s = 1'b0;
                end
                if (div_by_zero) begin
                    quo_s = 32'd0;
                    rem_s = 32'd0;
                end else begin
                    quo_s = mag_a_s / mag_b_s;
                    rem_s = mag_a_s % mag_b_s;
                end
                res_lo = (neg_a_s ^ neg_b_s) ? (32'd0 - quo_s) : quo_s;
                res_hi = neg_a_s ? (32'd0 - rem_s) : rem_s;
            end
            default: begin
                res_hi      = 32'd0;
                res_lo      = 32'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// The result is computed combinationally at issue and latched; a busy
// counter models the fixed operation latency before HI/LO are updated.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, md_op      E-stage mult/multu/div/divu issue
//   src_a, src_b      operands
//   hilo_we, hilo_sel, wdata   mthi/mtlo write
//   md_in_d           D-stage instruction is MD-class
//   flush             (only with MDU_FLUSH_EN) abort operation / squash issue
//   busy              operation in flight (registered)
//   stall             md_in_d & (start | busy), combinational
//   hi, lo            HI/LO registers
// Build option: define MDU_FLUSH_EN to add the flush input.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    input  logic        md_in_d,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        res_hi_r;
    logic [31:0]        res_lo_r;
    logic               dbz_r;

    logic [31:0]        arith_hi_s;
    logic [31:0]        arith_lo_s;
    logic               arith_dbz_s;
    logic               flush_s;
    logic               is_div_s;

`ifdef MDU_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign is_div_s = md_op[1];
    assign stall    = md_in_d & (start | busy);

    mdu_arith u_arith (
        .md_op       (md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .res_hi      (arith_hi_s),
        .res_lo      (arith_lo_s),
        .div_by_zero (arith_dbz_s)
    );

    // Sequencer: issue, latency countdown, HI/LO commit and mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            dbz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_s) begin
                        // Squashed issue slot: neither start nor mthi/mtlo.
                        busy <= 1'b0;
                    end else if (start) begin
                        res_hi_r <= arith_hi_s;
                        res_lo_r <= arith_lo_s;
                        dbz_r    <= arith_dbz_s;
                        cnt_r    <= is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy     <= 1'b1;
                        state_r  <= ST_BUSY;
                    end else if (hilo_we) begin
                        if (hilo_sel == HILO_SEL_HI) begin
                            hi <= wdata;
                        end else begin
                            lo <= wdata;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (flush_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_W'(1)) begin
                        // Divide by zero keeps the previous HI/LO.
                        if (!dbz_r) begin
                            hi <= res_hi_r;
                            lo <= res_lo_r;
                        end
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
